// File: rtl/gat_mac_pkg.sv
// Shared widths, tag layout and saturation helpers for the GAT multiply-accumulate pipe.
package gat_mac_pkg;

   localparam int DEF_A_WIDTH   = 12;
   localparam int DEF_B_WIDTH   = 8;
   localparam int DEF_P_WIDTH   = 18;
   localparam int DEF_ACC_WIDTH = 32;
   localparam int DEF_NUM_STAGE = 4;

   // Frame tags that travel alongside each beat through the product pipe.
   localparam int TAG_WIDTH = 2;
   localparam int TAG_FIRST = 0;
   localparam int TAG_LAST  = 1;

   // Width of the exact product of two operands.
   function automatic int full_width(input int a_w, input int b_w);
      return a_w + b_w;
   endfunction

   // Clamp an unsigned value into [0, 2^width-1].
   function automatic logic [63:0] sat_unsigned(input logic [63:0] value, input int width);
      logic [63:0] max_v;
      max_v = (64'd1 << width) - 64'd1;
      if (value > max_v) return max_v;
      return value;
   endfunction

   // Clamp a two's complement value into [-2^(width-1), 2^(width-1)-1].
   function automatic logic [63:0] sat_signed(input logic signed [63:0] value, input int width);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v = -max_v - 64'sd1;
      if (value > max_v) return max_v;
      if (value < min_v) return min_v;
      return value;
   endfunction

endpackage

// File: rtl/gat_mul_pipe.sv
// Pipelined signed/unsigned multiplier with clock enable and a parallel valid/tag shift register.
// Stage 1 holds the extended operands, stage 2 the product, later stages only delay.
module gat_mul_pipe
   import gat_mac_pkg::*;
#(
   parameter int A_WIDTH   = DEF_A_WIDTH,
   parameter int B_WIDTH   = DEF_B_WIDTH,
   parameter int NUM_STAGE = DEF_NUM_STAGE,
   parameter int SIGNED_A  = 0,
   parameter int SIGNED_B  = 0,
   localparam int PW       = full_width(A_WIDTH, B_WIDTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ce,
   input  logic                 in_valid,
   input  logic [A_WIDTH-1:0]   in_a,
   input  logic [B_WIDTH-1:0]   in_b,
   input  logic [TAG_WIDTH-1:0] in_tag,
   output logic                 out_valid,
   output logic [PW-1:0]        out_prod,
   output logic [TAG_WIDTH-1:0] out_tag
);

   logic [PW-1:0]        a_ext, b_ext;
   logic [PW-1:0]        a_q, b_q;
   logic [PW-1:0]        prod_q [2:NUM_STAGE];
   logic [NUM_STAGE:1]   valid_q;
   logic [TAG_WIDTH-1:0] tag_q  [1:NUM_STAGE];

   // Extend both operands to the full product width so one multiply serves every signedness mix.
   always_comb begin
      if (SIGNED_A != 0) a_ext = PW'($signed(in_a));
      else               a_ext = PW'(in_a);
      if (SIGNED_B != 0) b_ext = PW'($signed(in_b));
      else               b_ext = PW'(in_b);
   end

   // Operand, product and delay registers; reset flushes every in-flight beat, ce=0 freezes all.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q     <= '0;
         b_q     <= '0;
         valid_q <= '0;
         for (int i = 1; i <= NUM_STAGE; i++) tag_q[i] <= '0;
         for (int i = 2; i <= NUM_STAGE; i++) prod_q[i] <= '0;
      end else if (ce) begin
         a_q        <= a_ext;
         b_q        <= b_ext;
         valid_q[1] <= in_valid;
         tag_q[1]   <= in_tag;
         prod_q[2]  <= a_q * b_q;
         valid_q[2] <= valid_q[1];
         tag_q[2]   <= tag_q[1];
         for (int i = 3; i <= NUM_STAGE; i++) begin
            prod_q[i]  <= prod_q[i-1];
            valid_q[i] <= valid_q[i-1];
            tag_q[i]   <= tag_q[i-1];
         end
      end
   end

   assign out_valid = valid_q[NUM_STAGE];
   assign out_prod  = prod_q[NUM_STAGE];
   assign out_tag   = tag_q[NUM_STAGE];

endmodule

// File: rtl/gat_mac_pipe.sv
// Pipelined multiply-accumulate: product pipe, per-product result sizer, framed accumulator.
// Handshake: a beat is taken on every clk edge with ce=1 and in_valid=1 (no backpressure);
// out_valid / out_acc_valid are only meaningful on edges where ce=1, and hold while ce=0.
module gat_mac_pipe
   import gat_mac_pkg::*;
#(
   parameter int A_WIDTH   = DEF_A_WIDTH,
   parameter int B_WIDTH   = DEF_B_WIDTH,
   parameter int P_WIDTH   = DEF_P_WIDTH,
   parameter int ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int NUM_STAGE = DEF_NUM_STAGE,
   parameter int SIGNED_A  = 0,
   parameter int SIGNED_B  = 0,
   parameter int SAT_EN    = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ce,
   input  logic                 in_valid,
   input  logic [A_WIDTH-1:0]   in_a,
   input  logic [B_WIDTH-1:0]   in_b,
   input  logic                 in_first,
   input  logic                 in_last,
   output logic                 out_valid,
   output logic [P_WIDTH-1:0]   out_p,
   output logic                 out_acc_valid,
   output logic [ACC_WIDTH-1:0] out_acc,
   output logic                 acc_ovf
);

   localparam int PW      = full_width(A_WIDTH, B_WIDTH);
   localparam bit PSIGNED = (SIGNED_A != 0) || (SIGNED_B != 0);

   logic                 mul_valid;
   logic [PW-1:0]        mul_prod;
   logic [TAG_WIDTH-1:0] mul_tag;

   logic [63:0]          prod64;
   logic [ACC_WIDTH-1:0] prod_ext;
   logic [ACC_WIDTH-1:0] acc_q;
   logic [ACC_WIDTH:0]   sum_wide;
   logic [ACC_WIDTH-1:0] sat_val;
   logic                 add_ovf;
   logic [ACC_WIDTH-1:0] acc_next;
   logic                 ovf_next;

   gat_mul_pipe #(
      .A_WIDTH   (A_WIDTH),
      .B_WIDTH   (B_WIDTH),
      .NUM_STAGE (NUM_STAGE),
      .SIGNED_A  (SIGNED_A),
      .SIGNED_B  (SIGNED_B)
   ) u_mul (
      .clk       (clk),
      .reset     (reset),
      .ce        (ce),
      .in_valid  (in_valid),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    ({in_last, in_first}),
      .out_valid (mul_valid),
      .out_prod  (mul_prod),
      .out_tag   (mul_tag)
   );

   assign out_valid = mul_valid;

   // Size the product to P_WIDTH: plain truncation, or clamping to the signed/unsigned range.
   always_comb begin
      if (PSIGNED) prod64 = 64'($signed(mul_prod));
      else         prod64 = 64'(mul_prod);
      if (SAT_EN == 0)  out_p = mul_prod[P_WIDTH-1:0];
      else if (PSIGNED) out_p = P_WIDTH'(sat_signed(prod64, P_WIDTH));
      else              out_p = P_WIDTH'(sat_unsigned(prod64, P_WIDTH));
   end

   // Next accumulator value: first beat loads, otherwise add with overflow detect and optional clamp.
   always_comb begin
      if (PSIGNED) prod_ext = ACC_WIDTH'($signed(mul_prod));
      else         prod_ext = ACC_WIDTH'(mul_prod);
      sum_wide = {1'b0, acc_q} + {1'b0, prod_ext};
      if (PSIGNED) begin
         add_ovf = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                   (sum_wide[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
         sat_val = acc_q[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                      : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
         add_ovf = sum_wide[ACC_WIDTH];
         sat_val = '1;
      end
      if (mul_tag[TAG_FIRST]) begin
         acc_next = prod_ext;
         ovf_next = 1'b0;
      end else begin
         if (add_ovf && (SAT_EN != 0)) acc_next = sat_val;
         else                          acc_next = sum_wide[ACC_WIDTH-1:0];
         ovf_next = acc_ovf | add_ovf;
      end
   end

   // Accumulator stage: updates on valid beats, publishes the frame sum on the last beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q         <= '0;
         acc_ovf       <= 1'b0;
         out_acc       <= '0;
         out_acc_valid <= 1'b0;
      end else if (ce) begin
         out_acc_valid <= mul_valid & mul_tag[TAG_LAST];
         if (mul_valid) begin
            acc_q   <= acc_next;
            acc_ovf <= ovf_next;
            if (mul_tag[TAG_LAST]) out_acc <= acc_next;
         end
      end
   end

endmodule

// File: tb/tb_gat_mac_pipe.sv
// Directed bench for gat_mac_pipe: four instances share one stimulus stream
// (defaults, saturating, signed-a, narrow saturating accumulator).
module tb_gat_mac_pipe;

   logic        clk;
   logic        reset;
   logic        ce;
   logic        in_valid;
   logic [11:0] in_a;
   logic [7:0]  in_b;
   logic        in_first;
   logic        in_last;

   // default instance
   logic        dv, dav, dovf;
   logic [17:0] dp;
   logic [31:0] dacc;
   // SAT_EN=1 instance
   logic        sv, sav, sovf;
   logic [17:0] sp;
   logic [31:0] sacc;
   // SIGNED_A=1 instance
   logic        gv, gav, govf;
   logic [17:0] gp;
   logic [31:0] gacc;
   // ACC_WIDTH=20, SAT_EN=1 instance
   logic        cv, cav, covf;
   logic [17:0] cp;
   logic [19:0] cacc;

   int n_cmp;
   int n_bad;

   gat_mac_pipe u_def (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
      .in_first(in_first), .in_last(in_last), .out_valid(dv), .out_p(dp),
      .out_acc_valid(dav), .out_acc(dacc), .acc_ovf(dovf));

   gat_mac_pipe #(.SAT_EN(1)) u_sat (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
      .in_first(in_first), .in_last(in_last), .out_valid(sv), .out_p(sp),
      .out_acc_valid(sav), .out_acc(sacc), .acc_ovf(sovf));

   gat_mac_pipe #(.SIGNED_A(1)) u_sgn (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
      .in_first(in_first), .in_last(in_last), .out_valid(gv), .out_p(gp),
      .out_acc_valid(gav), .out_acc(gacc), .acc_ovf(govf));

   gat_mac_pipe #(.ACC_WIDTH(20), .SAT_EN(1)) u_acc (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
      .in_first(in_first), .in_last(in_last), .out_valid(cv), .out_p(cp),
      .out_acc_valid(cav), .out_acc(cacc), .acc_ovf(covf));

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // advance one clock, sample #1 after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [11:0] a, input logic [7:0] b,
                        input logic first, input logic last);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_first = first;
      in_last  = last;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      in_first = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      ce    = 1'b1;
      idle();
      tick();
      tick();
      reset = 1'b0;

      // reset state
      check_eq("rst_out_valid", dv, 0);
      check_eq("rst_out_p", dp, 0);
      check_eq("rst_acc_valid", dav, 0);
      check_eq("rst_out_acc", dacc, 0);
      check_eq("rst_acc_ovf", dovf, 0);

      // 1: max unsigned operands, latency and sizing
      drive(12'd4095, 8'd255, 1'b1, 1'b1);
      tick();
      idle();
      tick();
      tick();
      check_eq("t1_early_valid", dv, 0);
      tick();
      check_eq("t1_valid", dv, 1);
      check_eq("t1_trunc_p", dp, 18'h3EF01);
      check_eq("t1_sat_p", sp, 262143);
      check_eq("t1_acc20_sat_p", cp, 262143);
      tick();
      check_eq("t1_acc_valid", dav, 1);
      check_eq("t1_out_acc", dacc, 1044225);
      check_eq("t1_acc20_out_acc", cacc, 1044225);
      check_eq("t1_acc20_ovf", covf, 0);

      // 2: three-beat frame
      drive(12'd3, 8'd4, 1'b1, 1'b0);
      tick();
      drive(12'd5, 8'd6, 1'b0, 1'b0);
      tick();
      drive(12'd7, 8'd8, 1'b0, 1'b1);
      tick();
      idle();
      tick();
      check_eq("t2_p0", dp, 12);
      check_eq("t2_v0", dv, 1);
      tick();
      check_eq("t2_p1", dp, 30);
      tick();
      check_eq("t2_p2", dp, 56);
      check_eq("t2_acc_valid_early", dav, 0);
      tick();
      check_eq("t2_acc_valid", dav, 1);
      check_eq("t2_out_acc", dacc, 98);
      check_eq("t2_v_after", dv, 0);
      tick();
      check_eq("t2_acc_pulse_end", dav, 0);
      check_eq("t2_out_acc_hold", dacc, 98);

      // 3: signed operand a
      drive(12'hFFF, 8'd2, 1'b1, 1'b1);
      tick();
      idle();
      tick();
      tick();
      tick();
      check_eq("t3_sgn_valid", gv, 1);
      check_eq("t3_sgn_p", gp, 18'h3FFFE);
      tick();
      check_eq("t3_sgn_acc_valid", gav, 1);
      check_eq("t3_sgn_out_acc", gacc, 32'hFFFF_FFFE);
      check_eq("t3_sgn_ovf", govf, 0);

      // 4: ce stall with two beats in flight, in_valid ignored while ce=0
      drive(12'd9, 8'd10, 1'b1, 1'b0);
      tick();
      drive(12'd11, 8'd12, 1'b0, 1'b1);
      tick();
      ce = 1'b0;
      drive(12'd100, 8'd100, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("t4_stall_valid", dv, 0);
      end
      ce = 1'b1;
      idle();
      tick();
      check_eq("t4_delayed_valid", dv, 0);
      tick();
      check_eq("t4_v0", dv, 1);
      check_eq("t4_p0", dp, 90);
      ce = 1'b0;
      tick();
      check_eq("t4_hold_valid", dv, 1);
      check_eq("t4_hold_p", dp, 90);
      ce = 1'b1;
      tick();
      check_eq("t4_p1", dp, 132);
      check_eq("t4_acc_valid_early", dav, 0);
      tick();
      check_eq("t4_acc_valid", dav, 1);
      check_eq("t4_out_acc", dacc, 222);
      check_eq("t4_no_ghost_valid", dv, 0);
      tick();
      check_eq("t4_no_ghost_acc", dav, 0);
      check_eq("t4_no_ghost_valid2", dv, 0);

      // 5: reset mid-frame flushes the pipe
      drive(12'd13, 8'd14, 1'b1, 1'b0);
      tick();
      drive(12'd15, 8'd16, 1'b0, 1'b0);
      tick();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("t5_out_acc_zero", dacc, 0);
      for (int i = 0; i < 6; i++) begin
         check_eq("t5_no_valid", dv, 0);
         check_eq("t5_no_acc_valid", dav, 0);
         tick();
      end
      drive(12'd2, 8'd2, 1'b1, 1'b1);
      tick();
      idle();
      tick();
      tick();
      tick();
      check_eq("t5_p", dp, 4);
      tick();
      check_eq("t5_acc_valid", dav, 1);
      check_eq("t5_out_acc", dacc, 4);

      // 6: narrow accumulator saturates and flags overflow, next first clears it
      drive(12'd4095, 8'd255, 1'b1, 1'b0);
      tick();
      drive(12'd4095, 8'd255, 1'b0, 1'b1);
      tick();
      idle();
      tick();
      tick();
      tick();
      tick();
      check_eq("t6_acc_valid", cav, 1);
      check_eq("t6_out_acc_sat", cacc, 1048575);
      check_eq("t6_ovf", covf, 1);
      check_eq("t6_wide_out_acc", dacc, 2088450);
      check_eq("t6_wide_ovf", dovf, 0);
      drive(12'd1, 8'd1, 1'b1, 1'b1);
      tick();
      idle();
      tick();
      tick();
      tick();
      check_eq("t6_ovf_hold", covf, 1);
      check_eq("t6_out_acc_hold", cacc, 1048575);
      tick();
      check_eq("t6_ovf_cleared", covf, 0);
      check_eq("t6_out_acc_new", cacc, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
